// File: rtl/capture_arbiter_pkg.sv
// Shared types and default sizing for the capture arbiter.
// No logic; constants and the controller state encoding only.
// Imported by capture_arbiter and its testbench.
package capture_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int NREQ_DEFAULT = 4;
    localparam int DW_DEFAULT   = 8;

endpackage

// File: rtl/capture_arbiter_cap_reg.sv
// Shared capture register: loads d when enabled, clears to zero when disabled.
// Latency: one clock from d/en to q.
// No backpressure; the owner keeps en high and feeds q back to hold a value.
module cap_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    // Load on enable, otherwise fall back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else begin
            q <= '0;
        end
    end

endmodule

// File: rtl/capture_arbiter.sv
// Round-robin arbiter that captures one requester's word into a shared register.
// Latency: request at edge N -> grant at N+1 -> valid word at N+2.
// The word and grant are held until i_ack; requests are ignored while busy.
module capture_arbiter
    import capture_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*DW-1:0] i_data,
    input  logic               i_ack,
    output logic [NREQ-1:0]    o_gnt,
    output logic [DW-1:0]      o_q,
    output logic               o_valid
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   ptr_nxt;
    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] search;
    logic [NREQ-1:0] pick_onehot;
    logic            any_req;
    logic            cap_en;
    logic [DW-1:0]   cap_d;
    logic [DW-1:0]   win_dat;

    // Round-robin pick: lowest request at or above ptr, else lowest overall (wrap).
    always_comb begin
        any_req = |i_req;
        for (int k = 0; k < NREQ; k++) begin
            hi_mask[k] = (IW'(k) >= ptr);
        end
        hi_req = i_req & hi_mask;
        search = (|hi_req) ? hi_req : i_req;
        pick   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (search[k]) begin
                pick = IW'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            pick_onehot[k] = (pick == IW'(k));
        end
        ptr_nxt = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    end

    // Data slice of the current winner.
    always_comb begin
        win_dat = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == IW'(k)) begin
                win_dat = i_data[k*DW +: DW];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LOAD;
            LOAD:    state_nxt = HOLD;
            HOLD:    if (i_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture control: load in LOAD, recirculate in HOLD, clear otherwise.
    always_comb begin
        cap_en = (state == LOAD) || ((state == HOLD) && !i_ack);
        cap_d  = (state == LOAD) ? win_dat : o_q;
    end

    // Grant, winner and pointer bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_gnt <= '0;
            win   <= '0;
            ptr   <= '0;
        end else if ((state == IDLE) && any_req) begin
            o_gnt <= pick_onehot;
            win   <= pick;
        end else if ((state == HOLD) && i_ack) begin
            o_gnt <= '0;
            ptr   <= ptr_nxt;
        end
    end

    assign o_valid = (state == HOLD);

    cap_reg #(
        .DW (DW)
    ) u_cap_reg (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (cap_en),
        .d     (cap_d),
        .q     (o_q)
    );

endmodule

// File: tb/tb_capture_arbiter.sv
// Scoreboard bench: stimulus pushes expected captures, a monitor checks them.
// Reference model is a round-robin pointer over request vectors.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_capture_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [DW-1:0]   q;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] dat;
    logic               ack;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      q;
    logic               valid;

    int   total = 0;
    int   bad   = 0;
    int   mptr  = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic prev_valid = 1'b0;

    capture_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
        .i_data  (dat),
        .i_ack   (ack),
        .o_gnt   (gnt),
        .o_q     (q),
        .o_valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic push_exp(input int w, input logic [NREQ*DW-1:0] d);
        exp_t e;
        e.gnt    = '0;
        e.gnt[w] = 1'b1;
        e.q      = d[w*DW +: DW];
        exp_q.push_back(e);
    endtask

    // Monitor: each new valid word pops one expectation; held words must stay put.
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_capture", 32'd1, 32'd0);
            end else begin
                cur = exp_q.pop_front();
            end
        end
        if (valid) begin
            check("mon_q", 32'(q), 32'(cur.q));
            check("mon_gnt", 32'(gnt), 32'(cur.gnt));
        end
        prev_valid = valid;
    end

    // One full transaction; called at a falling edge while the DUT is idle.
    task automatic do_txn(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d,
                          input int dly, input bit drop, input logic [NREQ*DW-1:0] d2);
        int w;
        logic [NREQ-1:0] g;
        w    = rr_pick(r, mptr);
        g    = '0;
        g[w] = 1'b1;
        push_exp(w, d);
        req = r;
        dat = d;
        @(negedge clk);
        check("lat_gnt", 32'(gnt), 32'(g));
        check("lat_novalid", 32'(valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(valid), 32'd1);
        if (drop) req = r & ~g;
        dat = d2;
        repeat (dly) begin
            @(negedge clk);
            check("hold_valid", 32'(valid), 32'd1);
            check("hold_gnt", 32'(gnt), 32'(g));
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        req = '0;
        check("ack_valid", 32'(valid), 32'd0);
        check("ack_gnt", 32'(gnt), 32'd0);
        check("ack_q", 32'(q), 32'd0);
        mptr = (w + 1) % NREQ;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t, k, last;
        logic [NREQ-1:0] eg[5];
        logic [NREQ-1:0] pg;
        logic [NREQ*DW-1:0] d;

        rst_n = 1'b0;
        req   = 4'b1111;
        ack   = 1'b0;
        dat   = 32'h44332211;

        // Reset held with all requests asserted: nothing moves.
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_q", 32'(q), 32'd0);

        // Release reset with requests pending: requester 0 wins first.
        rst_n = 1'b1;
        mptr  = 0;
        do_txn(4'b1111, 32'h44332211, 0, 0, 32'h44332211);

        // Ack tied high, everyone requesting: strict rotation, 3 cycles apart.
        d = 32'hD4C3B2A1;
        for (int i = 0; i < 5; i++) begin
            int w;
            w     = rr_pick(4'b1111, mptr);
            eg[i] = '0;
            eg[i][w] = 1'b1;
            push_exp(w, d);
            mptr = (w + 1) % NREQ;
        end
        req = 4'b1111;
        dat = d;
        ack = 1'b1;
        k = 0; last = 0; pg = '0;
        for (t = 1; t <= 13; t++) begin
            @(negedge clk);
            if (gnt != 0 && pg == 0 && k < 5) begin
                check("rot_gnt", 32'(gnt), 32'(eg[k]));
                if (k > 0) check("rot_spacing", 32'(t - last), 32'd3);
                last = t;
                k++;
                if (k == 5) req = '0;
            end
            pg = gnt;
        end
        check("rot_count", 32'(k), 32'd5);
        @(negedge clk);
        @(negedge clk);
        ack = 1'b0;

        // Single requester 2, long hold, data changes during HOLD.
        do_txn(4'b0100, 32'h0000A500, 10, 0, 32'h003C0000 | 32'h00003C00);

        // Granted request dropped during HOLD, then acked; ptr must land on 3.
        do_txn(4'b0100, 32'h00770000, 3, 1, 32'h00770000);
        check("ptr_after_drop", 32'(mptr), 32'd3);
        do_txn(4'b1111, 32'h99887766, 0, 0, 32'h99887766);
        check("ptr3_wins3", 32'(cur.gnt), 32'b1000);

        // Ack while idle with no requests: no effect.
        req = '0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_ack_gnt", 32'(gnt), 32'd0);
            check("idle_ack_valid", 32'(valid), 32'd0);
            check("idle_ack_q", 32'(q), 32'd0);
        end

        // Randomized traffic.
        repeat (40) begin
            logic [NREQ-1:0] r;
            r = 4'($urandom_range(1, 15));
            do_txn(r, $urandom, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), $urandom);
        end

        // Reset between edges mid-HOLD: outputs clear at once, pointer returns to 0.
        do_txn(4'b0001, 32'h000000F1, 0, 0, 32'h0);
        push_exp(rr_pick(4'b0010, mptr), 32'h0000E200);
        req = 4'b0010;
        dat = 32'h0000E200;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_valid", 32'(valid), 32'd0);
        check("async_rst_q", 32'(q), 32'd0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mptr  = 0;
        do_txn(4'b1001, 32'h5A0000A5, 0, 0, 32'h5A0000A5);
        check("post_rst_winner", 32'(cur.gnt), 32'b0001);
        do_txn(4'b1000, 32'h5A0000A5, 1, 0, 32'h5A0000A5);

        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
